invader_hit_detect: RTL and testbench
=====================================

Name: invader_hit_detect

Overview:
- Sits directly downstream of the player controller. Consumes its bullet position and bullet-active flag, and returns the bullet_hit pulse it needs.
- Owns the alive mask of the invader grid. On each check tick it scans the grid cell by cell for a rectangle overlap with the player bullet, kills the first overlapping live invader, and reports the kill to score and wave logic.

Parameters:
- ROWS, 5, invader grid rows
- COLS, 11, invader grid columns
- INV_WIDTH, 32, invader sprite width in px
- INV_HEIGHT, 32, invader sprite height in px
- SPACING_X, 48, horizontal pitch between cell origins in px
- SPACING_Y, 40, vertical pitch between cell origins in px
- BULLET_WIDTH, 4, bullet width in px
- BULLET_HEIGHT, 16, bullet height in px

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- check_tick  in  1  one-cycle request to start a collision scan (once per frame)
- wave_load  in  1  one-cycle pulse: revive all invaders
- fleet_x  in  12  x of cell (0,0) top-left
- fleet_y  in  12  y of cell (0,0) top-left
- bullet_x  in  12  bullet left x, from xpos_shoot
- bullet_y  in  12  bullet top y
- bullet_active  in  1  bullet in flight
- bullet_hit  out  1  one-cycle hit pulse to the player controller
- kill_valid  out  1  one-cycle pulse, same cycle as bullet_hit
- kill_row  out  3  row of killed cell (valid with kill_valid)
- kill_col  out  4  column of killed cell (valid with kill_valid)
- alive  out  ROWS*COLS  alive mask; bit index r*COLS+c
- alive_count  out  6  number of live invaders
- all_dead  out  1  high when alive_count==0

Behaviour:
- Reset values:
  - alive all ones; alive_count=ROWS*COLS.
  - bullet_hit=0, kill_valid=0, kill_row=0, kill_col=0, all_dead=0.
  - hit_lock=0; FSM in IDLE.
- FSM states are IDLE and SCAN.
- IDLE:
  - A check_tick with bullet_active=1 and hit_lock=0 latches bullet_x, bullet_y, fleet_x and fleet_y.
  - Sets scan index k=0 and moves to SCAN.
  - A tick under any other condition is ignored.
- SCAN order:
  - Rows ROWS-1 down to 0 (bottom row first); within a row, cols 0 to COLS-1.
  - Index k=(ROWS-1-r)*COLS+c.
- SCAN evaluation:
  - One cell per cycle, using the latched coordinates.
  - Cell k is compared on the cycle after the edge that sampled the tick plus k. The tick is sampled at edge 0.
  - If cell k overlaps: the outputs below are registered at edge k+1 and the FSM returns to IDLE.
    - bullet_hit=1, kill_valid=1, kill_row=r, kill_col=c.
    - alive bit cleared; alive_count decremented; hit_lock set.
    - Outputs stay high for exactly one cycle.
- If the last cell is checked with no overlap, the FSM returns to IDLE with no pulse.
- Overlap is computed in 13-bit unsigned arithmetic, so there is no wrap:
  - cx = fleet_x + c*SPACING_X; cy = fleet_y + r*SPACING_Y.
  - Hit when the cell is alive, and bx < cx+INV_WIDTH, and cx < bx+BULLET_WIDTH, and by < cy+INV_HEIGHT, and cy < by+BULLET_HEIGHT.
  - Edges are half-open: touching edges do not hit.
- hit_lock:
  - Cleared whenever bullet_active=0.
  - Prevents re-hitting with the same bullet, which stays active until the player controller's next movement tick.
- bullet_active falling during SCAN aborts to IDLE; no pulse.
- check_tick during SCAN is ignored.
- wave_load:
  - Sets alive all ones, alive_count=ROWS*COLS and hit_lock=0.
  - Aborts any scan to IDLE.
  - Suppresses a hit pulse that would be registered in the same cycle.
- Priority: rst > wave_load > scan/hit.
- all_dead is registered and follows alive_count==0 one cycle later. It stays high until wave_load or rst.

Decomposition:
- invader_pkg holds:
  - ROWS, COLS, INV_WIDTH, INV_HEIGHT, SPACING_X, SPACING_Y;
  - the FSM state enum typedef (IDLE, SCAN);
  - the index-to-(row,col) helper function.
- Sub-module rect_overlap: combinational 13-bit half-open rectangle compare, reusable for the later invader-bullet vs player check.

Test Plan:
All scenarios use fleet=(100,60) and default parameters.
1. Bullet (110,240), active, tick:
   - Cell (4,0) spans x100-131, y220-251; k=0.
   - bullet_hit and kill_valid high one cycle at edge 1; kill_row=4, kill_col=0.
   - alive bit 44 cleared; alive_count=54.
2. Follow-on ticks:
   - Repeat tick with bullet_active still 1 -> no scan, no pulse (hit_lock).
   - Drop bullet_active for one cycle, raise it again, tick at same position -> full scan, no hit; row 3 spans y180-211.
3. Edge cases:
   - Bullet x=132, y=230 -> no hit (touching the right edge of col 0).
   - Bullet x=128, y=230 -> hit (4,0).
4. After rows 4 and 3 are killed via wave logic or sequential hits, bullet (150,150) -> hit (2,1) at edge 24 (k=23).
5. wave_load asserted on the same cycle the hit would register -> no bullet_hit; alive all ones; alive_count=55.
6. Kill all 55 cells one per tick -> alive_count=0; all_dead=1 next cycle; then wave_load -> all_dead=0, alive_count=55.

Source files
------------

// File: rtl/invader_pkg.sv
// Shared grid geometry, scan FSM states and the scan-index to cell mapping
// for the invader collision logic.
package invader_pkg;

  localparam int ROWS       = 5;
  localparam int COLS       = 11;
  localparam int INV_WIDTH  = 32;
  localparam int INV_HEIGHT = 32;
  localparam int SPACING_X  = 48;
  localparam int SPACING_Y  = 40;
  localparam int CELLS      = ROWS * COLS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [2:0] row;
    logic [3:0] col;
  } cell_rc_t;

  // Bottom row is scanned first: k=0 is (ROWS-1, 0).
  function automatic cell_rc_t idx_to_rc(input logic [5:0] k);
    cell_rc_t rc;
    rc.row = 3'(ROWS - 1 - int'(k) / COLS);
    rc.col = 4'(int'(k) % COLS);
    return rc;
  endfunction

endpackage

// File: rtl/invader_hit_detect_rect_overlap.sv
// Combinational half-open rectangle overlap in 13-bit unsigned space.
// Rect A at (ax,ay) of AW x AH, rect B at (bx,by) of BW x BH.
module rect_overlap #(
  parameter int AW = 32,
  parameter int AH = 32,
  parameter int BW = 4,
  parameter int BH = 16
) (
  input  logic [12:0] ax_i,
  input  logic [12:0] ay_i,
  input  logic [12:0] bx_i,
  input  logic [12:0] by_i,
  output logic        hit_o
);

  // Strict compares make touching edges a miss.
  assign hit_o = (bx_i < ax_i + 13'(AW)) && (ax_i < bx_i + 13'(BW)) &&
                 (by_i < ay_i + 13'(AH)) && (ay_i < by_i + 13'(BH));

endmodule

// File: rtl/invader_hit_detect.sv
// Owns the invader alive mask; scans one grid cell per cycle against the
// latched player bullet and kills the first overlapping live invader.
module invader_hit_detect
  import invader_pkg::*;
#(
  parameter int BULLET_WIDTH  = 4,
  parameter int BULLET_HEIGHT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             check_tick,
  input  logic             wave_load,
  input  logic [11:0]      fleet_x,
  input  logic [11:0]      fleet_y,
  input  logic [11:0]      bullet_x,
  input  logic [11:0]      bullet_y,
  input  logic             bullet_active,
  output logic             bullet_hit,
  output logic             kill_valid,
  output logic [2:0]       kill_row,
  output logic [3:0]       kill_col,
  output logic [CELLS-1:0] alive,
  output logic [5:0]       alive_count,
  output logic             all_dead
);

  scan_state_e      state_q, state_d;
  logic [5:0]       k_q, k_d;
  logic [11:0]      bx_q, by_q, fx_q, fy_q;
  logic             hit_lock_q;
  logic [CELLS-1:0] alive_q;
  logic [5:0]       cnt_q;
  logic             hit_q;
  logic [2:0]       row_q;
  logic [3:0]       col_q;
  logic             all_dead_q;

  cell_rc_t    rc;
  logic [12:0] cx, cy;
  logic [5:0]  cell_idx;
  logic        ovl, cell_alive, hit_now, last_cell, scan_start;

  assign rc         = idx_to_rc(k_q);
  assign cx         = {1'b0, fx_q} + 13'(32'(rc.col) * SPACING_X);
  assign cy         = {1'b0, fy_q} + 13'(32'(rc.row) * SPACING_Y);
  assign cell_idx   = 6'(32'(rc.row) * COLS + 32'(rc.col));
  assign cell_alive = alive_q[cell_idx];
  assign last_cell  = (k_q == 6'(CELLS - 1));

  rect_overlap #(
    .AW(INV_WIDTH),
    .AH(INV_HEIGHT),
    .BW(BULLET_WIDTH),
    .BH(BULLET_HEIGHT)
  ) u_ovl (
    .ax_i (cx),
    .ay_i (cy),
    .bx_i ({1'b0, bx_q}),
    .by_i ({1'b0, by_q}),
    .hit_o(ovl)
  );

  // A bullet that drops mid-scan, or a wave reload, cancels any pending kill.
  assign hit_now    = (state_q == SCAN) && bullet_active && cell_alive && ovl && !wave_load;
  assign scan_start = (state_q == IDLE) && check_tick && bullet_active && !hit_lock_q && !wave_load;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (scan_start) begin
        state_d = SCAN;
        k_d     = '0;
      end
      SCAN: if (!bullet_active || hit_now || last_cell) state_d = IDLE;
            else k_d = k_q + 6'd1;
      default: state_d = IDLE;
    endcase
    if (wave_load) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      fx_q       <= '0;
      fy_q       <= '0;
      hit_lock_q <= 1'b0;
      alive_q    <= '1;
      cnt_q      <= 6'(CELLS);
      hit_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      all_dead_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      hit_q      <= hit_now;
      all_dead_q <= !wave_load && (cnt_q == '0);
      if (scan_start) begin
        bx_q <= bullet_x;
        by_q <= bullet_y;
        fx_q <= fleet_x;
        fy_q <= fleet_y;
      end
      if (wave_load) begin
        alive_q    <= '1;
        cnt_q      <= 6'(CELLS);
        hit_lock_q <= 1'b0;
      end else if (hit_now) begin
        alive_q[cell_idx] <= 1'b0;
        cnt_q             <= cnt_q - 6'd1;
        hit_lock_q        <= 1'b1;
        row_q             <= rc.row;
        col_q             <= rc.col;
      end else if (!bullet_active) begin
        hit_lock_q <= 1'b0;
      end
    end
  end

  assign bullet_hit  = hit_q;
  assign kill_valid  = hit_q;
  assign kill_row    = row_q;
  assign kill_col    = col_q;
  assign alive       = alive_q;
  assign alive_count = cnt_q;
  assign all_dead    = all_dead_q;

endmodule

// File: tb/tb_invader_hit_detect.sv
// Scoreboard bench: shots are resolved by a geometric reference model and the
// expected kills are queued; a monitor checks every pulse the DUT produces.
module tb_invader_hit_detect;

  localparam int NR = 5, NC = 11, NCELL = 55;

  logic        clk = 1'b0, rst = 1'b1, check_tick = 1'b0, wave_load = 1'b0;
  logic [11:0] fleet_x = '0, fleet_y = '0, bullet_x = '0, bullet_y = '0;
  logic        bullet_active = 1'b0;
  logic        bullet_hit, kill_valid, all_dead;
  logic [2:0]  kill_row;
  logic [3:0]  kill_col;
  logic [NCELL-1:0] alive;
  logic [5:0]  alive_count;

  invader_hit_detect dut (
    .clk(clk), .rst(rst), .check_tick(check_tick), .wave_load(wave_load),
    .fleet_x(fleet_x), .fleet_y(fleet_y), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_active(bullet_active), .bullet_hit(bullet_hit), .kill_valid(kill_valid),
    .kill_row(kill_row), .kill_col(kill_col), .alive(alive),
    .alive_count(alive_count), .all_dead(all_dead)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: invaders as a 2-D array, geometry straight from the rules.
  bit m_alive [NR][NC];
  int m_cnt;
  bit m_lock;

  typedef struct { int row; int col; int cyc; int cnt; } exp_t;
  exp_t expq[$];
  int   last_pulse_cyc = -1;
  int   dead_chk_cyc = -1;

  function automatic int find_hit(int fx, int fy, int bx, int by);
    for (int r = NR - 1; r >= 0; r--)
      for (int c = 0; c < NC; c++) begin
        int cx = fx + c * 48;
        int cy = fy + r * 40;
        if (m_alive[r][c] && bx < cx + 32 && cx < bx + 4 && by < cy + 32 && cy < by + 16)
          return (NR - 1 - r) * NC + c;
      end
    return -1;
  endfunction

  function automatic logic [NCELL-1:0] model_mask();
    logic [NCELL-1:0] m;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) m[r * NC + c] = m_alive[r][c];
    return m;
  endfunction

  function automatic void model_revive();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) m_alive[r][c] = 1'b1;
    m_cnt  = NCELL;
    m_lock = 1'b0;
  endfunction

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bullet_hit || kill_valid) begin
        last_pulse_cyc = cyc;
        if (expq.size() == 0) begin
          chk("unexpected_pulse", {bullet_hit, kill_valid}, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("bullet_hit", bullet_hit, 1);
          chk("kill_valid", kill_valid, 1);
          chk("kill_row", kill_row, e.row);
          chk("kill_col", kill_col, e.col);
          chk("pulse_cycle", cyc, e.cyc);
          chk("alive_bit_cleared", alive[e.row * NC + e.col], 0);
          chk("alive_count_at_kill", alive_count, e.cnt);
          if (e.cnt == 0) begin
            chk("all_dead_same_cycle", all_dead, 0);
            dead_chk_cyc = cyc + 1;
          end
        end
      end
      if (cyc == dead_chk_cyc) chk("all_dead_next_cycle", all_dead, 1);
    end
  end

  task automatic check_state(input string nm);
    chk({nm, "_alive"}, alive, model_mask());
    chk({nm, "_count"}, alive_count, m_cnt);
  endtask

  // One shot: optional one-cycle bullet drop, then a tick; waits out a full scan.
  task automatic fire(input int fx, input int fy, input int bx, input int by,
                      input bit drop, output int tick_edge);
    int k;
    if (drop) begin
      @(posedge clk); #1 bullet_active = 1'b0;
      m_lock = 1'b0;
    end
    @(posedge clk); #1;
    fleet_x = 12'(fx); fleet_y = 12'(fy); bullet_x = 12'(bx); bullet_y = 12'(by);
    bullet_active = 1'b1; check_tick = 1'b1;
    tick_edge = cyc + 1;
    k = m_lock ? -1 : find_hit(fx, fy, bx, by);
    if (k >= 0) begin
      exp_t e;
      e.row = NR - 1 - k / NC;
      e.col = k % NC;
      m_alive[e.row][e.col] = 1'b0;
      m_cnt--;
      m_lock = 1'b1;
      e.cyc = tick_edge + k + 1;
      e.cnt = m_cnt;
      expq.push_back(e);
    end
    @(posedge clk); #1 check_tick = 1'b0;
    repeat (NCELL + 2) @(posedge clk);
    #1;
  endtask

  task automatic wave();
    @(posedge clk); #1 wave_load = 1'b1;
    @(posedge clk); #1 wave_load = 1'b0;
    model_revive();
  endtask

  task automatic shoot_cell(input int r, input int c);
    int te;
    fire(100, 60, 100 + c * 48 + 14, 60 + r * 40 + 8, 1'b1, te);
  endtask

  initial begin
    int te;
    int order[NCELL];
    model_revive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alive", alive, {NCELL{1'b1}});
    chk("rst_count", alive_count, NCELL);
    chk("rst_hit", bullet_hit, 0);
    chk("rst_kill_valid", kill_valid, 0);
    chk("rst_kill_row", kill_row, 0);
    chk("rst_kill_col", kill_col, 0);
    chk("rst_all_dead", all_dead, 0);
    rst = 1'b0;

    // Bottom-left cell on the first scan slot.
    fire(100, 60, 110, 240, 1'b1, te);
    chk("t1_latency", last_pulse_cyc - te, 1);
    check_state("t1");
    // Same bullet still active: locked out.
    fire(100, 60, 110, 240, 1'b0, te);
    check_state("t2_locked");
    // Fresh bullet at the same spot: cell already dead, full scan, no hit.
    fire(100, 60, 110, 240, 1'b1, te);
    check_state("t2_rescan");

    wave();
    fire(100, 60, 132, 230, 1'b1, te);
    check_state("t3_touch_right");
    fire(100, 60, 128, 230, 1'b1, te);
    check_state("t3_inside_right");

    for (int r = 3; r <= 4; r++)
      for (int c = 0; c < NC; c++)
        if (m_alive[r][c]) shoot_cell(r, c);
    check_state("t4_rows_cleared");
    fire(100, 60, 150, 150, 1'b1, te);
    chk("t4_latency", last_pulse_cyc - te, 24);
    check_state("t4");

    // Reload on the very edge that would register the kill.
    wave();
    @(posedge clk); #1 bullet_active = 1'b0;
    @(posedge clk); #1;
    fleet_x = 12'd100; fleet_y = 12'd60; bullet_x = 12'd110; bullet_y = 12'd240;
    bullet_active = 1'b1; check_tick = 1'b1;
    @(posedge clk); #1 check_tick = 1'b0; wave_load = 1'b1;
    @(posedge clk); #1 wave_load = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_state("t5_wave_vs_hit");

    // Randomized shots, including fleets near the top of the coordinate range.
    for (int i = 0; i < 40; i++) begin
      int fx, fy, bx, by;
      if (i % 8 == 7) begin
        fx = $urandom_range(3600, 4095); fy = $urandom_range(3800, 4095);
        bx = $urandom_range(3600, 4095); by = $urandom_range(3800, 4095);
      end else begin
        fx = $urandom_range(0, 400); fy = $urandom_range(0, 200);
        bx = $urandom_range(fx, fx + 540); by = $urandom_range(fy, fy + 220);
      end
      fire(fx, fy, bx, by, ($urandom_range(0, 3) != 0), te);
      if (i % 4 == 3) check_state("rand");
      if (i == 20) wave();
    end

    // Bullet vanishes mid-scan, before reaching its target cell (k=54).
    wave();
    @(posedge clk); #1 bullet_active = 1'b0;
    @(posedge clk); #1;
    fleet_x = 12'd100; fleet_y = 12'd60;
    bullet_x = 12'(100 + 10 * 48 + 14); bullet_y = 12'd68;
    bullet_active = 1'b1; check_tick = 1'b1;
    @(posedge clk); #1 check_tick = 1'b0;
    repeat (20) @(posedge clk);
    #1 bullet_active = 1'b0;
    repeat (50) @(posedge clk);
    #1 check_state("abort");

    // Clear the whole wave in a random order.
    wave();
    for (int i = 0; i < NCELL; i++) order[i] = i;
    for (int i = NCELL - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < NCELL; i++) shoot_cell(order[i] / NC, order[i] % NC);
    check_state("t6_cleared");
    chk("t6_all_dead_held", all_dead, 1);
    wave();
    #1;
    chk("t6_all_dead_after_wave", all_dead, 0);
    check_state("t6_after_wave");

    chk("queue_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
